// File: rtl/sync_fifo_wrctrl.sv
// rtl/sync_fifo_wrctrl.sv - write-side controller of the synchronous FIFO
// Sticky overflow flag is built only when SYNC_FIFO_WR_OVF_EN is defined.
module sync_fifo_wrctrl #(
  parameter int AW       = 7,
  parameter int DW       = 32,
  parameter int AFULL_TH = 120
) (
  input  logic          wclk_i,
  input  logic          rst_n,
  input  logic          wenable,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] rpnt_i,
  input  logic          ovf_clr,
  output logic          wenable_o,
  output logic          wclk_o,
  output logic [DW-1:0] wdata_o,
  output logic [AW-1:0] wpnt_o,
  output logic          full_o,
  output logic          afull_o,
  output logic [AW-1:0] wcount_o,
  output logic          ovf_o
);

  localparam logic [AW-1:0] AFULL_LVL = AW'(AFULL_TH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [AW-1:0] wpnt_q, wpnt_d;
  logic [AW-1:0] wcount;
  logic          full;
  logic          wr_en;

  // One slot stays unused, so equal pointers always mean empty.
  assign wcount = wpnt_q - rpnt_i;
  assign full   = (wcount == {AW{1'b1}});
  assign wr_en  = rst_n & wenable & ~full;

  always_comb begin
    wpnt_d = wpnt_q;
    if (wr_en) begin
      wpnt_d = wpnt_q + PTR_ONE;
    end
  end

  always_ff @(posedge wclk_i or negedge rst_n) begin
    if (!rst_n) begin
      wpnt_q <= '0;
    end else begin
      wpnt_q <= wpnt_d;
    end
  end

`ifdef SYNC_FIFO_WR_OVF_EN
  logic ovf_q, ovf_d;

  // A dropped write on the same edge as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (rst_n & wenable & full) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge wclk_i or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_o          = 1'b0;
`endif

  assign wenable_o = wr_en;
  assign wclk_o    = wclk_i;
  assign wdata_o   = wdata_i;
  assign wpnt_o    = wpnt_q;
  assign full_o    = full;
  assign afull_o   = (wcount >= AFULL_LVL);
  assign wcount_o  = wcount;

endmodule

// File: tb/tb_sync_fifo_wrctrl.sv
// tb/tb_sync_fifo_wrctrl.sv - self-checking bench for sync_fifo_wrctrl
// Integer-arithmetic reference model plus directed literal expectations.
module tb_sync_fifo_wrctrl;
  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int DEPTH = 128;
  localparam int ATH   = 120;
`ifdef SYNC_FIFO_WR_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wenable;
  logic [DW-1:0] wdata;
  logic [AW-1:0] rpnt;
  logic          ovf_clr;
  logic          wenable_o, wclk_o, full_o, afull_o, ovf_o;
  logic [DW-1:0] wdata_o;
  logic [AW-1:0] wpnt_o, wcount_o;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  int m_wp;
  bit m_ovf;
  logic [DW-1:0] tb_mem [DEPTH];

  sync_fifo_wrctrl #(.AW(AW), .DW(DW), .AFULL_TH(ATH)) dut (
    .wclk_i(clk), .rst_n(rst_n), .wenable(wenable), .wdata_i(wdata),
    .rpnt_i(rpnt), .ovf_clr(ovf_clr), .wenable_o(wenable_o), .wclk_o(wclk_o),
    .wdata_o(wdata_o), .wpnt_o(wpnt_o), .full_o(full_o), .afull_o(afull_o),
    .wcount_o(wcount_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  always @(posedge wclk_o) begin
    if (wenable_o) tb_mem[wpnt_o] <= wdata_o;
  end

  function automatic int exp_count();
    return ((m_wp - int'(rpnt)) % DEPTH + DEPTH) % DEPTH;
  endfunction

  function automatic bit exp_full();
    return exp_count() == DEPTH - 1;
  endfunction

  function automatic bit exp_accept();
    return rst_n && wenable && !exp_full();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wp  <= 0;
      m_ovf <= 1'b0;
    end else begin
      if (exp_accept()) m_wp <= (m_wp + 1) % DEPTH;
      if (OVF_EN) begin
        if (wenable && exp_full()) m_ovf <= 1'b1;
        else if (ovf_clr)          m_ovf <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_wpnt",   int'(wpnt_o),   m_wp);
      check("m_wcount", int'(wcount_o), exp_count());
      check("m_full",   int'(full_o),   int'(exp_full()));
      check("m_afull",  int'(afull_o),  int'(exp_count() >= ATH));
      check("m_wen",    int'(wenable_o), int'(exp_accept()));
      check("m_ovf",    int'(ovf_o),    int'(m_ovf));
      check("m_wdata",  int'(wdata_o == wdata), 1);
      check("m_wclk",   int'(wclk_o),   int'(clk));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int bad;
  int exp_wp [4] = '{127, 0, 1, 2};
  int exp_wc [4] = '{27, 28, 29, 30};

  initial begin
    rst_n = 1'b0; wenable = 1'b0; wdata = '0; rpnt = '0; ovf_clr = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();
    check("rst_wpnt", wpnt_o, 0);
    check("rst_wcount", wcount_o, 0);
    check("rst_full", full_o, 0);
    check("rst_afull", afull_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_wen", wenable_o, 0);

    for (int k = 0; k < 120; k++) begin
      wenable = 1'b1;
      wdata = DW'(k);
      tick();
      if (k == 118) check("afull_119", afull_o, 0);
    end
    check("afull_120", afull_o, 1);
    check("wcount_120", wcount_o, 120);

    for (int k = 120; k < 127; k++) begin
      wdata = DW'(k);
      tick();
    end
    check("full_127", full_o, 1);
    check("wpnt_127", wpnt_o, 127);
    check("wcount_127", wcount_o, 127);

    wdata = 32'hEE;
    #1;
    check("drop_wen", wenable_o, 0);
    tick();
    check("drop_wpnt", wpnt_o, 127);
    check("drop_ovf", ovf_o, int'(OVF_EN));

    bad = 0;
    for (int k = 0; k < 127; k++) if (tb_mem[k] !== DW'(k)) bad++;
    check("mem_fill", bad, 0);

    wdata = 32'hAA;
    tick();
    check("rdwr_full_wpnt", wpnt_o, 127);
    rpnt = 7'd1;
    #1;
    check("rdwr_next_wen", wenable_o, 1);
    tick();
    check("rdwr_wrap_wpnt", wpnt_o, 0);
    check("rdwr_full_again", full_o, 1);
    check("rdwr_mem127", int'(tb_mem[127]), 32'hAA);

    ovf_clr = 1'b1;
    tick();
    check("ovf_set_wins", ovf_o, int'(OVF_EN));
    wenable = 1'b0;
    rpnt = 7'd10;
    tick();
    check("ovf_cleared", ovf_o, 0);
    ovf_clr = 1'b0;

    rst_n = 1'b0;
    rpnt = '0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 126; k++) begin
      wenable = 1'b1;
      wdata = DW'(1000 + k);
      tick();
    end
    check("pre_wrap_wpnt", wpnt_o, 126);
    check("pre_wrap_full", full_o, 0);
    rpnt = 7'd100;
    #1;
    check("pre_wrap_wcount", wcount_o, 26);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wrap_wpnt", wpnt_o, exp_wp[i]);
      check("wrap_wcount", wcount_o, exp_wc[i]);
    end

    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_wpnt", wpnt_o, 0);
    check("async_rst_wen", wenable_o, 0);
    check("async_rst_ovf", ovf_o, 0);
    tick();
    rst_n = 1'b1;
    wenable = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
